pipe_stage_reg: RTL and testbench

//  Parametrised pipeline stage register with valid/ready handshake, flush and optional skid buffer.

---
 rtl/pipe_stage_reg.sv | 96 +++++++++
 tb/tb_pipe_stage_reg.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with a valid/ready handshake,
// flush, and an optional 2-entry skid buffer.
//
// Parameters
//   WIDTH      payload width in bits (>= 1)
//   RESET_VAL  payload driven on reset, on flush and whenever out_valid = 0 (bubble)
//   SKID       1: main + skid entry, in_ready is a register output
//              0: single entry, in_ready = !out_valid | out_ready
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   flush      squash every held entry this cycle; data offered this cycle is dropped
//   in_valid   upstream offers in_data
//   in_ready   stage accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  out_data carries a live payload
//   out_ready  downstream consumes out_data this cycle
//   out_data   payload to the downstream stage
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 7,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q,  m_data_d;
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] s_data_q,  s_data_d;
  logic             accept, pop;

  // With the skid entry, in_ready depends on state only, so out_ready never reaches in_ready.
  assign in_ready  = SKID ? !s_valid_q : (!m_valid_q || out_ready);
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;

  assign accept = in_valid && in_ready;
  assign pop    = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (SKID) begin
      if (!m_valid_q || pop) begin
        if (s_valid_q) begin
          // Skid entry is older than anything offered now, so it moves up first.
          m_valid_d = 1'b1;
          m_data_d  = s_data_q;
          s_valid_d = accept;
          s_data_d  = accept ? in_data : RESET_VAL;
        end else begin
          m_valid_d = accept;
          m_data_d  = accept ? in_data : RESET_VAL;
        end
      end else if (accept) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data;
      end
    end else begin
      s_valid_d = 1'b0;
      s_data_d  = RESET_VAL;
      if (!m_valid_q || out_ready) begin
        m_valid_d = in_valid;
        m_data_d  = in_valid ? in_data : RESET_VAL;
      end
    end
  end

  // Flush yields exactly the reset state; reset wins over flush but the outcome is identical.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_valid_q <= 1'b0;
      m_data_q  <= RESET_VAL;
      s_valid_q <= 1'b0;
      s_data_q  <= RESET_VAL;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random scoreboard bench for pipe_stage_reg.
// Index 1 is the SKID=1 instance, index 0 the SKID=0 instance.
module tb_pipe_stage_reg;

  logic       clk;
  logic       rst;
  logic       flush     [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [6:0] in_data   [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [6:0] out_data  [2];

  int n_total;
  int n_bad;

  pipe_stage_reg #(.WIDTH(7), .RESET_VAL(7'h00), .SKID(1'b1)) u_dut_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush[1]),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_data  (out_data[1])
  );

  pipe_stage_reg #(.WIDTH(7), .RESET_VAL(7'h00), .SKID(1'b0)) u_dut_noskid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush[0]),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_data  (out_data[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lands 1 time unit after the rising edge; registered outputs are settled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic v, input logic [6:0] d, input logic r);
    in_valid[idx]  = v;
    in_data[idx]   = d;
    out_ready[idx] = r;
  endtask

  task automatic check_out(input string tag, input int idx, input logic v, input logic [6:0] d);
    check({tag, "_valid"}, out_valid[idx], v);
    check({tag, "_data"}, out_data[idx], d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Fill the SKID=1 instance with 11 (main) and 22 (skid) under stall.
  task automatic fill_skid();
    drive(1, 1'b1, 7'h11, 1'b0);
    tick();
    drive(1, 1'b1, 7'h22, 1'b0);
    tick();
    in_valid[1] = 1'b0;
    check("fill_full_rdy", in_ready[1], 1'b0);
  endtask

  task automatic rand_run(input int idx, input int cycles);
    logic [6:0] q[$];
    logic [6:0] exp;
    logic       acc, pop, hold;
    int         bound;
    bound = (idx == 1) ? 2 : 1;
    hold  = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (!hold) begin
        in_valid[idx] = ($urandom_range(0, 3) != 0);
        in_data[idx]  = 7'($urandom_range(0, 127));
      end
      out_ready[idx] = ($urandom_range(0, 3) != 0);
      flush[idx]     = ($urandom_range(0, 63) == 0);
      #1;
      check("rnd_valid", out_valid[idx], q.size() != 0);
      if (idx == 1) check("rnd_rdy", in_ready[idx], q.size() < 2);
      else          check("rnd_rdy", in_ready[idx], (q.size() == 0) || out_ready[idx]);
      if (!out_valid[idx]) check("rnd_bubble", out_data[idx], 7'h00);
      acc = in_valid[idx] && in_ready[idx];
      pop = out_valid[idx] && out_ready[idx];
      if (pop) begin
        if (q.size() == 0) begin
          check("rnd_spurious", 1'b1, 1'b0);
        end else begin
          exp = q.pop_front();
          check("rnd_data", out_data[idx], exp);
        end
      end
      if (flush[idx]) q.delete();
      else if (acc) q.push_back(in_data[idx]);
      check("rnd_depth", q.size() <= bound, 1'b1);
      hold = in_valid[idx] && !acc && !flush[idx];
      tick();
    end
    drive(idx, 1'b0, 7'h00, 1'b0);
    flush[idx] = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < 2; i++) begin
      flush[i] = 1'b0;
      drive(i, 1'b0, 7'h00, 1'b0);
    end
    rst = 1'b0;
    #2;

    // Reset
    do_reset();
    for (int i = 0; i < 2; i++) begin
      check_out("rst", i, 1'b0, 7'h00);
      check("rst_rdy", in_ready[i], 1'b1);
    end

    // Streaming, SKID=1
    drive(1, 1'b1, 7'h11, 1'b1);
    tick();
    check_out("str1_a", 1, 1'b1, 7'h11);
    in_data[1] = 7'h22;
    tick();
    check_out("str1_b", 1, 1'b1, 7'h22);
    in_data[1] = 7'h33;
    tick();
    check_out("str1_c", 1, 1'b1, 7'h33);
    in_valid[1] = 1'b0;
    tick();
    check_out("str1_d", 1, 1'b0, 7'h00);

    // Stall and skid, SKID=1
    drive(1, 1'b1, 7'h11, 1'b0);
    tick();
    check_out("stl_a", 1, 1'b1, 7'h11);
    check("stl_a_rdy", in_ready[1], 1'b1);
    in_data[1] = 7'h22;
    tick();
    check_out("stl_b", 1, 1'b1, 7'h11);
    check("stl_b_rdy", in_ready[1], 1'b0);
    in_data[1] = 7'h33;
    tick();
    check_out("stl_c", 1, 1'b1, 7'h11);
    check("stl_c_rdy", in_ready[1], 1'b0);
    out_ready[1] = 1'b1;
    tick();
    check_out("stl_d", 1, 1'b1, 7'h22);
    check("stl_d_rdy", in_ready[1], 1'b1);
    tick();
    check_out("stl_e", 1, 1'b1, 7'h33);
    in_valid[1] = 1'b0;
    tick();
    check_out("stl_f", 1, 1'b0, 7'h00);

    // Flush while full, with data offered
    fill_skid();
    drive(1, 1'b1, 7'h44, 1'b0);
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    drive(1, 1'b0, 7'h00, 1'b1);
    check_out("fls_a", 1, 1'b0, 7'h00);
    check("fls_a_rdy", in_ready[1], 1'b1);
    tick();
    check_out("fls_b", 1, 1'b0, 7'h00);
    // Flush voids a handshake that in_ready accepted
    drive(1, 1'b1, 7'h44, 1'b1);
    flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    in_valid[1] = 1'b0;
    check_out("fls_c", 1, 1'b0, 7'h00);
    tick();
    check_out("fls_d", 1, 1'b0, 7'h00);

    // Reset mid-stall, then reset together with flush
    fill_skid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("rstm_a", 1, 1'b0, 7'h00);
    check("rstm_a_rdy", in_ready[1], 1'b1);
    fill_skid();
    rst      = 1'b1;
    flush[1] = 1'b1;
    tick();
    rst      = 1'b0;
    flush[1] = 1'b0;
    check_out("rstm_b", 1, 1'b0, 7'h00);
    check("rstm_b_rdy", in_ready[1], 1'b1);

    // Streaming, SKID=0
    drive(0, 1'b1, 7'h11, 1'b1);
    tick();
    check_out("str0_a", 0, 1'b1, 7'h11);
    in_data[0] = 7'h22;
    tick();
    check_out("str0_b", 0, 1'b1, 7'h22);
    in_data[0] = 7'h33;
    tick();
    check_out("str0_c", 0, 1'b1, 7'h33);
    in_valid[0] = 1'b0;
    tick();
    check_out("str0_d", 0, 1'b0, 7'h00);

    // Stall, SKID=0: in_ready follows out_ready in the same cycle
    drive(0, 1'b1, 7'h11, 1'b0);
    #1;
    check("st0_a_rdy", in_ready[0], 1'b1);
    tick();
    in_data[0] = 7'h22;
    #1;
    check("st0_b_rdy", in_ready[0], 1'b0);
    tick();
    check_out("st0_b", 0, 1'b1, 7'h11);
    out_ready[0] = 1'b1;
    #1;
    check("st0_c_rdy", in_ready[0], 1'b1);
    tick();
    check_out("st0_c", 0, 1'b1, 7'h22);
    in_data[0] = 7'h33;
    tick();
    check_out("st0_d", 0, 1'b1, 7'h33);
    in_valid[0] = 1'b0;
    tick();
    check_out("st0_e", 0, 1'b0, 7'h00);

    // Random valid/ready/flush scoreboard on both builds
    rand_run(1, 10000);
    rand_run(0, 10000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
